// File: rtl/ps2_host_if.sv
`timescale 1ns/1ps
// ps2_host_if
// Host-side bus of the PS/2 host controller: command byte handshake toward the
// device and the receive FIFO / status pulses toward the keyboard decoder.
//   tx_valid/tx_data/tx_ready : command byte offer and acceptance
//   tx_done/tx_fail           : one-cycle transmit outcome pulses
//   rx_valid/rx_data/rx_pop   : first-word-fall-through receive FIFO head
//   rx_level                  : FIFO occupancy
//   rx_err/rx_overflow        : one-cycle receive status pulses
// master = decoder side, slave = ps2_host side.
interface ps2_host_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          tx_done;
    logic          tx_fail;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_pop;
    logic [LW-1:0] rx_level;
    logic          rx_err;
    logic          rx_overflow;

    modport master (
        output tx_valid, tx_data, rx_pop,
        input  tx_ready, tx_done, tx_fail, rx_valid, rx_data, rx_level, rx_err, rx_overflow
    );

    modport slave (
        input  tx_valid, tx_data, rx_pop,
        output tx_ready, tx_done, tx_fail, rx_valid, rx_data, rx_level, rx_err, rx_overflow
    );
endinterface

// File: rtl/ps2_host.sv
`timescale 1ns/1ps
// ps2_host
// PS/2 host controller between the open-drain PS/2 pads and the keyboard
// decoder. Receives device frames into a FIFO with start/stop/odd-parity
// checking, transmits command bytes with inhibit/request sequencing, checks the
// device ACK and retries on NACK or line timeout.
// Ports:
//   clk, resetn               : system clock, asynchronous active-low reset
//   ps2_clk_in, ps2_data_in   : raw (unsynchronised) pad inputs
//   ps2_clk_oe, ps2_data_oe   : 1 = pull the corresponding line low
//   host                      : ps2_host_if.slave (tx handshake, rx FIFO, status)
module ps2_host #(
    parameter int unsigned CLK_HZ      = 25_125_000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEBOUNCE    = 5,
    parameter int unsigned MAX_RETRIES = 2,
    parameter int unsigned TIMEOUT_US  = 2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    ps2_host_if.slave   host
);
    // Protocol delays in clock cycles, rounded up; 64-bit to avoid overflow.
    localparam logic [63:0] INHIBIT_CYC = (64'(CLK_HZ) * 64'd100 + 64'd999_999) / 64'd1_000_000;
    localparam logic [63:0] REQ_CYC     = (64'(CLK_HZ) * 64'd20 + 64'd999_999) / 64'd1_000_000;
    localparam logic [63:0] TIMEOUT_CYC = (64'(CLK_HZ) * 64'(TIMEOUT_US) + 64'd999_999) / 64'd1_000_000;
    localparam logic [63:0] MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;

    localparam int unsigned TMR_W = $clog2(MAX_CYC + 64'd1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned AT_W  = $clog2(MAX_RETRIES + 2);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;

    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYC - 64'd1);
    localparam logic [TMR_W-1:0] REQ_LAST = TMR_W'(REQ_CYC - 64'd1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYC - 64'd1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronisers, debounce filter on the clock line.
    // ------------------------------------------------------------------
    logic [1:0]      clk_s;
    logic [1:0]      dat_s;
    logic            clk_filt;
    logic [DB_W-1:0] db_cnt;
    logic            fall;
    logic            dat_sync;

    assign dat_sync = dat_s[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_filt <= 1'b1;
            db_cnt   <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk_in};
            dat_s <= {dat_s[0], ps2_data_in};
            fall  <= 1'b0;
            if (clk_s[1] == clk_filt) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                // Level accepted after DEBOUNCE differing samples; the edge
                // strobe is raised in the same cycle the filtered level drops.
                clk_filt <= clk_s[1];
                db_cnt   <= '0;
                fall     <= clk_filt;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t           state;
    logic [3:0]       bit_cnt;
    logic [9:0]       rx_sh;
    logic [9:0]       tx_frame;
    logic [9:0]       tx_sh;
    logic [TMR_W-1:0] tmr;
    logic [AT_W-1:0]  attempt;
    logic             nack;
    logic             push;
    logic [7:0]       push_data;
    logic             tx_ready;

    assign tx_ready      = (state == IDLE) && clk_filt;
    assign host.tx_ready = tx_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_sh        <= '0;
            tx_frame     <= '0;
            tx_sh        <= '0;
            tmr          <= '0;
            attempt      <= '0;
            nack         <= 1'b0;
            push         <= 1'b0;
            push_data    <= '0;
            ps2_clk_oe   <= 1'b0;
            ps2_data_oe  <= 1'b0;
            host.tx_done <= 1'b0;
            host.tx_fail <= 1'b0;
            host.rx_err  <= 1'b0;
        end else begin
            host.tx_done <= 1'b0;
            host.tx_fail <= 1'b0;
            host.rx_err  <= 1'b0;
            push         <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= RX;
                        bit_cnt <= 4'd1;
                        rx_sh   <= {dat_sync, rx_sh[9:1]};
                        tmr     <= '0;
                    end else if (host.tx_valid && tx_ready) begin
                        tx_frame   <= {1'b1, ~^host.tx_data, host.tx_data};
                        attempt    <= AT_W'(1);
                        ps2_clk_oe <= 1'b1;
                        tmr        <= '0;
                        state      <= TX_INHIBIT;
                    end
                end

                RX: begin
                    if (fall) begin
                        tmr     <= '0;
                        rx_sh   <= {dat_sync, rx_sh[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd10) begin
                            // rx_sh holds start..parity; dat_sync is the stop bit.
                            state <= IDLE;
                            if (!rx_sh[0] && dat_sync && (^rx_sh[9:1])) begin
                                push      <= 1'b1;
                                push_data <= rx_sh[8:1];
                            end else begin
                                host.rx_err <= 1'b1;
                            end
                        end
                    end else if (tmr == TO_LAST) begin
                        host.rx_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                TX_INHIBIT: begin
                    if (tmr == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        tmr         <= '0;
                        state       <= TX_REQ;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                TX_REQ: begin
                    if (tmr == REQ_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        tmr        <= '0;
                        bit_cnt    <= '0;
                        tx_sh      <= tx_frame;
                        state      <= TX_BITS;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                TX_BITS: begin
                    if (fall) begin
                        tmr         <= '0;
                        ps2_data_oe <= ~tx_sh[0];
                        tx_sh       <= {1'b0, tx_sh[9:1]};
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            state <= TX_ACK;
                        end
                    end else if (tmr == TO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        nack        <= 1'b1;
                        state       <= TX_RELEASE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                TX_ACK: begin
                    if (fall) begin
                        nack        <= dat_sync;
                        ps2_data_oe <= 1'b0;
                        state       <= TX_RELEASE;
                    end else if (tmr == TO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        nack        <= 1'b1;
                        state       <= TX_RELEASE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                TX_RELEASE: begin
                    if (clk_filt && dat_sync) begin
                        if (!nack) begin
                            host.tx_done <= 1'b1;
                            attempt      <= '0;
                            state        <= IDLE;
                        end else if (32'(attempt) <= MAX_RETRIES) begin
                            attempt    <= attempt + 1'b1;
                            ps2_clk_oe <= 1'b1;
                            tmr        <= '0;
                            state      <= TX_INHIBIT;
                        end else begin
                            host.tx_fail <= 1'b1;
                            attempt      <= '0;
                            state        <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO: circular buffer, first-word-fall-through head.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = host.rx_pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            host.rx_overflow <= 1'b0;
        end else begin
            host.rx_overflow <= push && full && !pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign host.rx_valid = !empty;
    assign host.rx_data  = mem[rd_ptr];
    assign host.rx_level = count;
endmodule

// File: tb/tb_ps2_host.sv
`timescale 1ns/1ps
// tb_ps2_host
// Self-checking bench for ps2_host: a PS/2 device model drives the open-drain
// lines, a queue-based reference model predicts FIFO contents, error and
// overflow counts, and transmit outcomes.
module tb_ps2_host;
    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DB      = 3;
    localparam int unsigned RETRIES = 2;
    localparam int unsigned TO_US   = 300;
    localparam int INH  = 100;
    localparam int TOC  = 300;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    always #5 clk = ~clk;

    // Open-drain wired-AND of device and host.
    assign ps2_clk_in  = ~(dev_clk_low | ps2_clk_oe);
    assign ps2_data_in = ~(dev_data_low | ps2_data_oe);

    ps2_host_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_host #(
        .CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .DEBOUNCE(DB),
        .MAX_RETRIES(RETRIES), .TIMEOUT_US(TO_US)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .host(bus)
    );

    // Event monitor
    int cyc = 0, n_err = 0, n_ovf = 0, n_done = 0, n_fail = 0, n_req = 0;
    int oe_run = 0, last_oe_run = 0;
    logic oe_prev = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        n_err  <= n_err + int'(bus.rx_err);
        n_ovf  <= n_ovf + int'(bus.rx_overflow);
        n_done <= n_done + int'(bus.tx_done);
        n_fail <= n_fail + int'(bus.tx_fail);
        n_req  <= n_req + int'(ps2_clk_oe && !oe_prev);
        oe_prev <= ps2_clk_oe;
        if (ps2_clk_oe) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            last_oe_run <= oe_run;
            oe_run <= 0;
        end
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int checks = 0, errors = 0;
    logic [7:0] q[$];
    int exp_err = 0, exp_ovf = 0;
    int last_dev_fall = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Odd parity bit from the population count of the byte.
    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_par(d), d, 1'b0};
    endfunction

    // Device clocks out the first nbits of a frame, LSB first.
    task automatic dev_send(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~fr[i];
            tick(HALF / 2);
            dev_clk_low = 1'b1;
            last_dev_fall = cyc;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF / 2);
        end
        dev_data_low = 1'b0;
        tick(HALF);
    endtask

    // Device sends a frame; reference model decides its fate.
    task automatic rx_frame(input logic [7:0] d, input int bad);
        logic [10:0] fr;
        fr = make_frame(d);
        if (bad == 1) fr[9] = ~fr[9];
        if (bad == 2) fr[0] = 1'b1;
        if (bad == 3) fr[10] = 1'b0;
        dev_send(fr, 11);
        if (bad != 0) exp_err++;
        else if (q.size() == DEPTH) exp_ovf++;
        else q.push_back(d);
        tick(4);
    endtask

    task automatic rx_check(input string tag);
        check({tag, "_level"}, 32'(bus.rx_level), 32'(q.size()));
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, "_data"}, 32'(bus.rx_data), 32'(q[0]));
        check({tag, "_errs"}, 32'(n_err), 32'(exp_err));
        check({tag, "_ovfs"}, 32'(n_ovf), 32'(exp_ovf));
    endtask

    task automatic pop_one();
        check("pop_data", 32'(bus.rx_data), 32'(q[0]));
        bus.rx_pop = 1'b1;
        tick(1);
        bus.rx_pop = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic host_send(input logic [7:0] d);
        int w;
        w = 0;
        while (!bus.tx_ready && w < 200) begin
            tick(1);
            w++;
        end
        check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        tick(1);
        bus.tx_valid = 1'b0;
        check("tx_ready_drop", 32'(bus.tx_ready), 32'd0);
    endtask

    // One host-to-device attempt from the device side.
    task automatic dev_tx(input logic ack, output logic [9:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && w < INH + 300) begin
            tick(1);
            w++;
        end
        check("tx_request", 32'(ps2_data_oe && !ps2_clk_oe), 32'd1);
        tick(10);
        for (int i = 0; i < 11; i++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            if (i < 10) bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (i == 9 && ack) dev_data_low = 1'b1;
            tick(HALF);
        end
        dev_data_low = 1'b0;
        tick(2);
    endtask

    task automatic tx_ack_case(input logic [7:0] d);
        logic [9:0] bits;
        int d0, w;
        d0 = n_done;
        host_send(d);
        dev_tx(1'b1, bits);
        check("tx_bits", 32'(bits[7:0]), 32'(d));
        check("tx_parity", 32'(bits[8]), 32'(odd_par(d)));
        check("tx_stop", 32'(bits[9]), 32'd1);
        check("inhibit_len", 32'(last_oe_run >= INH), 32'd1);
        w = 0;
        while (n_done == d0 && w < 100) begin
            tick(1);
            w++;
        end
        check("tx_done", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        int e0, f0, d0, r0, w, delta;
        logic [7:0] rb;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_pop   = 1'b0;

        tick(3);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_level", 32'(bus.rx_level), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_pulses", 32'({bus.tx_done, bus.tx_fail, bus.rx_err, bus.rx_overflow}), 32'd0);
        resetn = 1'b1;
        tick(10);

        // Good frame, then a parity-corrupted one.
        rx_frame(8'h1C, 0);
        rx_check("rx_1c");
        rx_frame(8'hAA, 1);
        rx_check("rx_aa_bad");
        pop_one();
        rx_check("rx_pop1");

        // Fill past capacity with no pops, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom), 0);
        rx_check("rx_full");
        while (q.size() != 0) pop_one();
        tick(1);
        rx_check("rx_drained");

        // Randomised frames with random corruption and random pops.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0 && q.size() != 0) pop_one();
            rx_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            rx_check("rx_rand");
        end
        while (q.size() != 0) pop_one();
        tick(1);
        rx_check("rx_rand_drained");

        // Clock stalls after 4 bits; watchdog must flag the frame.
        e0 = n_err;
        dev_send(make_frame(8'h3C), 4);
        w = 0;
        while (n_err == e0 && w < TOC + 200) begin
            tick(1);
            w++;
        end
        delta = cyc - last_dev_fall;
        check("stall_err", 32'(n_err - e0), 32'd1);
        check("stall_window", 32'(delta >= TOC && delta <= TOC + int'(DB) + 10), 32'd1);
        exp_err++;
        rx_frame(8'h5A, 0);
        rx_check("rx_5a");
        pop_one();

        // Host transmit with ACK.
        tx_ack_case(8'hED);
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            tx_ack_case(rb);
        end

        // NACK every attempt: 1 + RETRIES attempts, then tx_fail.
        d0 = n_done;
        f0 = n_fail;
        r0 = n_req;
        host_send(8'hF4);
        for (int a = 0; a < RETRIES + 1; a++) begin
            dev_tx(1'b0, bits);
            check("nack_bits", 32'(bits[7:0]), 32'hF4);
        end
        tick(50);
        check("nack_fail", 32'(n_fail - f0), 32'd1);
        check("nack_no_done", 32'(n_done - d0), 32'd0);
        check("nack_attempts", 32'(n_req - r0), 32'(RETRIES + 1));
        tick(INH * 2);
        check("nack_no_fourth", 32'(n_req - r0), 32'(RETRIES + 1));
        check("nack_idle_ready", 32'(bus.tx_ready), 32'd1);

        // Asynchronous reset during inhibit releases the lines at once.
        host_send(8'h12);
        tick(20);
        check("inhibit_active", 32'(ps2_clk_oe), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        tick(3);
        resetn = 1'b1;
        tick(5);
        check("post_rst_level", 32'(bus.rx_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
